// File: rtl/ysyx_25020037_axi_rd_arbiter_if.sv
// Read-channel bundle between N upstream AXI4 read masters, the arbiter and the downstream port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ysyx_25020037_axi_rd_arbiter_if #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
);
    // Upstream side, one lane per master (master i at [i*W +: W])
    logic [N-1:0]    m_arvalid;
    logic [N-1:0]    m_arready;
    logic [N*AW-1:0] m_araddr;
    logic [N*17-1:0] m_arctl;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_rready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [3:0]      m_rid;

    // Downstream side
    logic            s_arvalid;
    logic            s_arready;
    logic [AW-1:0]   s_araddr;
    logic [16:0]     s_arctl;
    logic            s_rvalid;
    logic            s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [3:0]      s_rid;

    modport slave (
        input  m_arvalid, m_araddr, m_arctl, m_rready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
        output s_arvalid, s_araddr, s_arctl, s_rready
    );

    modport master (
        output m_arvalid, m_araddr, m_arctl, m_rready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
        input  s_arvalid, s_araddr, s_arctl, s_rready
    );
endinterface

// File: rtl/ysyx_25020037_axi_rd_arbiter.sv
// N-to-1 AXI4 read arbiter: one owner holds the downstream port from AR handshake to the last R beat.
// Define YSYX_25020037_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority, index 0 highest.
module ysyx_25020037_axi_rd_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    ysyx_25020037_axi_rd_arbiter_if.slave        bus,
    output logic [N-1:0]                         grant
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;

`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N) j = j - N;
        return IW'(j);
    endfunction
`endif

    // Scanning from the far end lets the highest-priority requester overwrite earlier picks.
    always_comb begin
        winner = '0;
`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.m_arvalid[rot_idx(rr_ptr, k)]) winner = rot_idx(rr_ptr, k);
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.m_arvalid[k]) winner = IW'(k);
        end
`endif
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_arvalid) begin
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        owner         <= winner;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.s_arvalid && bus.s_arready) state <= DATA;
                end
                DATA: begin
                    if (bus.s_rvalid && bus.s_rready && bus.s_rlast) begin
                        state <= IDLE;
                        grant <= '0;
`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
                        rr_ptr <= (int'(owner) == N - 1) ? '0 : owner + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // NOTE: every output is given a default before the case so no latch can be inferred.
    always_comb begin
        bus.m_arready = '0;
        bus.m_rvalid  = '0;
        bus.s_arvalid = 1'b0;
        bus.s_araddr  = '0;
        bus.s_arctl   = '0;
        bus.s_rready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                if (state == ADDR) begin
                    bus.s_arvalid    = bus.m_arvalid[i];
                    bus.s_araddr     = bus.m_araddr[i*AW +: AW];
                    bus.s_arctl      = bus.m_arctl[i*CW +: CW];
                    bus.m_arready[i] = bus.s_arready;
                end else if (state == DATA) begin
                    bus.m_rvalid[i] = bus.s_rvalid;
                    bus.s_rready    = bus.m_rready[i];
                end
            end
        end
    end

    // R payload is broadcast; only rvalid is steered to the owner.
    assign bus.m_rdata = bus.s_rdata;
    assign bus.m_rresp = bus.s_rresp;
    assign bus.m_rlast = bus.s_rlast;
    assign bus.m_rid   = bus.s_rid;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_idle_no_grant: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE) |-> (grant == '0));
endmodule

// File: tb/tb_ysyx_25020037_axi_rd_arbiter.sv
// Directed bench for the AXI read arbiter: transaction-level owner model checked every cycle,
// plus literal expectations per scenario. Honours YSYX_25020037_ARB_ROUND_ROBIN_EN.
module tb_ysyx_25020037_axi_rd_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] grant;
    int           vectors = 0;
    int           errors  = 0;

    ysyx_25020037_axi_rd_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    ysyx_25020037_axi_rd_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the port (-1 = nobody) and whether its address was already accepted.
    int own       = -1;
    bit addr_done = 1'b0;
    int ptr       = 0;

    function automatic int pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            int j;
`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
            j = (ptr + k) % N;
`else
            j = k;
`endif
            if (req[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            own       = -1;
            addr_done = 1'b0;
            ptr       = 0;
        end else if (own < 0) begin
            if (|bus.m_arvalid) begin
                own       = pick(bus.m_arvalid);
                addr_done = 1'b0;
            end
        end else if (!addr_done) begin
            if (bus.m_arvalid[own] && bus.s_arready) addr_done = 1'b1;
        end else if (bus.s_rvalid && bus.m_rready[own] && bus.s_rlast) begin
`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
            ptr = (own + 1) % N;
`endif
            own       = -1;
            addr_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_grant, e_arready, e_rvalid;
        logic         e_arvalid, e_rready;
        e_grant   = '0;
        e_arready = '0;
        e_rvalid  = '0;
        e_arvalid = 1'b0;
        e_rready  = 1'b0;
        if (own >= 0) begin
            e_grant[own] = 1'b1;
            if (!addr_done) begin
                e_arvalid      = bus.m_arvalid[own];
                e_arready[own] = bus.s_arready;
            end else begin
                e_rvalid[own] = bus.s_rvalid;
                e_rready      = bus.m_rready[own];
            end
        end
        check("cyc_grant",     grant,         e_grant);
        check("cyc_s_arvalid", bus.s_arvalid, e_arvalid);
        check("cyc_m_arready", bus.m_arready, e_arready);
        check("cyc_m_rvalid",  bus.m_rvalid,  e_rvalid);
        check("cyc_s_rready",  bus.s_rready,  e_rready);
        check("cyc_m_rdata",   bus.m_rdata,   bus.s_rdata);
        check("cyc_m_rlast",   bus.m_rlast,   bus.s_rlast);
        check("cyc_m_rid",     bus.m_rid,     bus.s_rid);
        if (e_arvalid) begin
            check("cyc_s_araddr", bus.s_araddr, bus.m_araddr[own*AW +: AW]);
            check("cyc_s_arctl",  bus.s_arctl,  bus.m_arctl[own*17 +: 17]);
        end
    end

    function automatic logic [16:0] mk_ctl(input logic [3:0] id, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
        return {id, len, size, burst};
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [16:0] ctl);
        bus.m_araddr[i*AW +: AW] = addr;
        bus.m_arctl[i*17 +: 17]  = ctl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] data, input logic last);
        bus.s_rvalid = 1'b1;
        bus.s_rdata  = data;
        bus.s_rlast  = last;
    endtask

    task automatic no_beat();
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_g;
        int           beats;
        bus.m_arvalid = '0;
        bus.m_araddr  = '0;
        bus.m_arctl   = '0;
        bus.m_rready  = '0;
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b1;   // stray R beat during reset and IDLE must be ignored
        bus.s_rdata   = 32'hDEAD_BEEF;
        bus.s_rresp   = 2'b00;
        bus.s_rlast   = 1'b1;
        bus.s_rid     = 4'h0;
        bus.m_rready  = 2'b11;

        #3;
        check("rst_grant",     grant,         2'b00);
        check("rst_s_rready",  bus.s_rready,  1'b0);
        check("rst_m_rvalid",  bus.m_rvalid,  2'b00);
        check("rst_s_arvalid", bus.s_arvalid, 1'b0);
        check("rst_m_arready", bus.m_arready, 2'b00);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        check("idle_stray_s_rready", bus.s_rready, 1'b0);
        check("idle_stray_m_rvalid", bus.m_rvalid, 2'b00);
        no_beat();

        // Single request from master 1
        set_req(1, 32'hA000_0048, mk_ctl(4'h1, 8'd0, 3'd2, 2'b01));
        bus.m_arvalid = 2'b10;
        bus.s_arready = 1'b1;
        #1 check("t1_idle_grant", grant, 2'b00);
        step();
        #1;
        check("t1_grant",     grant,         2'b10);
        check("t1_s_araddr",  bus.s_araddr,  32'hA000_0048);
        check("t1_s_arctl",   bus.s_arctl,   {4'h1, 8'd0, 3'd2, 2'b01});
        check("t1_m_arready", bus.m_arready, 2'b10);
        step();
        bus.m_arvalid = 2'b00;
        bus.s_rid     = 4'h1;
        beat(32'h1234_5678, 1'b1);
        #1;
        check("t1_m_rvalid", bus.m_rvalid, 2'b10);
        check("t1_m_rdata",  bus.m_rdata,  32'h1234_5678);
        step();
        no_beat();
        #1 check("t1_grant_idle", grant, 2'b00);

        // Simultaneous requests: master 0 first, master 1 once master 0 drops arvalid
        set_req(0, 32'h8000_0000, mk_ctl(4'h0, 8'd0, 3'd2, 2'b01));
        set_req(1, 32'h8000_0100, mk_ctl(4'h1, 8'd0, 3'd2, 2'b01));
        bus.m_arvalid = 2'b11;
        step();
        #1;
        check("t2_grant0",    grant,         2'b01);
        check("t2_m_arready", bus.m_arready, 2'b01);
        step();
        bus.m_arvalid = 2'b10;
        beat(32'hCAFE_0000, 1'b1);
        #1 check("t2_data_arready", bus.m_arready, 2'b00);
        step();
        no_beat();
        #1 check("t2_gap_grant", grant, 2'b00);
        step();
        #1;
        check("t2_grant1",   grant,        2'b10);
        check("t2_s_araddr", bus.s_araddr, 32'h8000_0100);
        step();
        bus.m_arvalid = 2'b00;
        beat(32'hCAFE_0001, 1'b1);
        step();
        no_beat();

        // Both masters hold arvalid for four transactions
        bus.m_arvalid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef YSYX_25020037_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            #1 check("t3_grant_seq", grant, exp_g);
            step();
            beat(32'h3000_0000 + i, 1'b1);
            step();
            no_beat();
        end
        bus.m_arvalid = 2'b00;
        step();

        // Four-beat burst to master 0 with rready toggling; master 1 waits
        set_req(0, 32'h8000_1000, mk_ctl(4'h2, 8'd3, 3'd2, 2'b01));
        set_req(1, 32'h8000_2000, mk_ctl(4'h3, 8'd0, 3'd2, 2'b01));
        bus.m_arvalid = 2'b01;
        step();
        #1 check("t4_grant", grant, 2'b01);
        step();
        bus.m_arvalid = 2'b10;
        beats = 0;
        for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
            bus.m_rready = {1'b1, (cyc % 3 != 1)};
            beat(32'hB000_0000 + beats, beats == 3);
            #1;
            check("t4_m_rvalid",   bus.m_rvalid,  2'b01);
            check("t4_m_arready",  bus.m_arready, 2'b00);
            check("t4_s_arvalid",  bus.s_arvalid, 1'b0);
            if (bus.m_rready[0]) beats++;
            step();
        end
        check("t4_beats", beats, 4);
        no_beat();
        bus.m_rready = 2'b11;
        #1;
        check("t4_after_grant",   grant,         2'b00);
        check("t4_after_arready", bus.m_arready, 2'b00);
        step();
        #1;
        check("t4_next_grant",   grant,         2'b10);
        check("t4_next_arready", bus.m_arready, 2'b10);
        check("t4_next_araddr",  bus.s_araddr,  32'h8000_2000);
        step();
        bus.m_arvalid = 2'b00;
        beat(32'hB100_0000, 1'b1);
        step();
        no_beat();

        // Downstream holds off arready for five cycles
        set_req(0, 32'h0200_BFF8, mk_ctl(4'h4, 8'd0, 3'd3, 2'b01));
        bus.s_arready = 1'b0;
        bus.m_arvalid = 2'b01;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_s_arvalid", bus.s_arvalid, 1'b1);
            check("t5_s_araddr",  bus.s_araddr,  32'h0200_BFF8);
            check("t5_s_arctl",   bus.s_arctl,   {4'h4, 8'd0, 3'd3, 2'b01});
            check("t5_m_arready", bus.m_arready, 2'b00);
            step();
        end
        bus.s_arready = 1'b1;
        #1 check("t5_release_arready", bus.m_arready, 2'b01);
        step();
        bus.m_arvalid = 2'b00;
        beat(32'h0000_0055, 1'b1);
        step();
        no_beat();

        // Asynchronous reset between beats 2 and 3 of a burst
        set_req(1, 32'h8000_3000, mk_ctl(4'h5, 8'd3, 3'd2, 2'b01));
        bus.m_arvalid = 2'b10;
        step();
        step();
        bus.m_arvalid = 2'b00;
        beat(32'hC000_0000, 1'b0);
        step();
        beat(32'hC000_0001, 1'b0);
        step();
        beat(32'hC000_0002, 1'b0);
        rst = 1'b0;
        #1;
        check("t6_rst_s_rready", bus.s_rready, 1'b0);
        check("t6_rst_m_rvalid", bus.m_rvalid, 2'b00);
        check("t6_rst_grant",    grant,        2'b00);
        step();
        rst = 1'b1;
        no_beat();
        set_req(0, 32'h8000_4000, mk_ctl(4'h6, 8'd0, 3'd2, 2'b01));
        bus.m_arvalid = 2'b01;
        step();
        #1 check("t6_post_grant", grant, 2'b01);
        step();
        bus.m_arvalid = 2'b00;
        beat(32'hC100_0000, 1'b1);
        step();
        no_beat();
        #1 check("t6_post_idle", grant, 2'b00);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_25020037_axi_rd_arbiter.md
Name: ysyx_25020037_axi_rd_arbiter

Overview:
- N-to-1 AXI4 read-channel arbiter that lets several read masters (IFU = port 0, LSU = port 1 by default) share one downstream read port.
- The downstream port feeds the crossbar/slave side: CLINT, SRAM, peripherals.
- Grants one master at a time and holds that grant from AR handshake through the last R beat (rlast).
- Routes AR forward and R back with no added latency once granted.

Parameters:
- N, 2, number of requesting masters (2..4); index 0 = highest fixed priority.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst  in  1  asynchronous, active-low reset; all state cleared while low.
- m_arvalid  in  N  per-master AR valid.
- m_arready  out  N  per-master AR ready.
- m_araddr  in  N*AW  per-master address, master i at [i*AW +: AW].
- m_arctl  in  N*17  per-master {arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0]}.
- m_rvalid  out  N  per-master R valid.
- m_rready  in  N  per-master R ready.
- m_rdata  out  DW  shared R data (broadcast).
- m_rresp  out  2  shared R resp (broadcast).
- m_rlast  out  1  shared R last (broadcast).
- m_rid  out  4  shared R id (broadcast).
- s_arvalid  out  1  downstream AR valid.
- s_arready  in  1  downstream AR ready.
- s_araddr  out  AW  downstream address.
- s_arctl  out  17  downstream {arid, arlen, arsize, arburst}.
- s_rvalid  in  1  downstream R valid.
- s_rready  out  1  downstream R ready.
- s_rdata/s_rresp/s_rlast/s_rid  in  DW/2/1/4  downstream R payload.
- grant  out  N  one-hot current owner; 0 in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE, grant register = 0, RR pointer = 0.
  - All outputs 0: m_arready, m_rvalid, s_arvalid, s_rready, grant.
- IDLE:
  - All readies and valids are 0.
  - If any m_arvalid is set, the winner is registered into grant and the FSM moves to ADDR.
  - Arbitration takes exactly 1 cycle, so s_arvalid rises the cycle after m_arvalid at the earliest.
- ADDR (grant = g):
  - Combinational pass-through: s_arvalid = m_arvalid[g], s_araddr/s_arctl = master g fields, m_arready[g] = s_arready.
  - All other m_arready bits are 0.
  - On s_arvalid & s_arready, go to DATA.
  - A master withdrawing arvalid (protocol violation) keeps the FSM in ADDR; no re-arbitration.
- DATA:
  - m_rvalid[g] = s_rvalid, s_rready = m_rready[g]; all other m_rvalid bits are 0.
  - s_arvalid = 0 and all m_arready bits are 0; no new AR is accepted during a burst.
  - On s_rvalid & s_rready & s_rlast, go to IDLE, clear grant, and update the RR pointer (if enabled).
  - Beats without rlast keep the FSM in DATA (multi-beat bursts of arlen+1 beats).
- Broadcast R payload:
  - m_rdata/m_rresp/m_rlast/m_rid mirror s_* at all times.
  - Only m_rvalid is gated per master.
- Back-to-back: the minimum gap between the last R handshake and the next s_arvalid is 1 cycle (IDLE arbitration cycle).
- Simultaneous requests in IDLE are resolved by the arbitration policy below; losers keep arvalid high and wait without loss.
- s_rvalid asserted in IDLE or ADDR is ignored (s_rready = 0).
- Reset mid-burst: immediate return to IDLE. The downstream slave is reset by the same rst, so no transaction is left outstanding.
- grant is a register output; it changes only on the IDLE→ADDR and DATA→IDLE transitions.

Optional Feature:
- Macro: YSYX_25020037_ARB_ROUND_ROBIN_EN
- Defined:
  - Round-robin arbitration. A registered pointer p (reset 0) holds the index after the last completed owner.
  - Search order is p, p+1, …, N-1, 0, …, p-1, wrapping.
  - On DATA→IDLE, p = (g+1) mod N.
- Undefined:
  - Fixed priority; the lowest index wins.
  - No pointer flop exists.
  - The LSU (1) can starve behind a continuously requesting IFU (0).

Test Plan:
- Single request: m_arvalid=2'b10, araddr1=0xA000_0048, arlen=0; slave returns rdata=0x1234_5678 with rlast=1. Required: grant=2'b10 one cycle later; s_araddr=0xA000_0048; m_rvalid=2'b10 with m_rdata=0x1234_5678; FSM back to IDLE, grant=0.
- Simultaneous requests, fixed priority: both arvalid set each cycle. Required: master 0 is served first, then master 1 only after master 0 deasserts arvalid; m_arready[1] stays 0 throughout master 0's transaction.
- Simultaneous requests, round-robin (macro defined): both arvalid held high for 4 transactions. Required: grant sequence 01,10,01,10.
- Burst: arlen=3, slave rlast on beat 4, m_rready toggled 1,0,1. Required: 4 beats delivered to the owner only; a new AR from the other master is not accepted until the cycle after beat 4 completes.
- Slave backpressure: s_arready low for 5 cycles. Required: the FSM stays in ADDR, s_arvalid stays 1, and address/ctl stay stable.
- Async reset mid-DATA: rst pulled low between beats 2 and 3. Required: s_rready, m_rvalid and grant are 0 immediately; after rst is released, a new request is arbitrated normally.
